// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM state type and line-level constants.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

    localparam logic UART_IDLE_LVL  = 1'b1;
    localparam logic UART_START_LVL = 1'b0;
    localparam logic UART_STOP_LVL  = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        WAIT   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd5,
`endif
        STOP   = 3'd6
    } tx_state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period down-counter: load reloads CLK_DIV-1, bit_done flags a count of zero.
module uart_bit_timer #(
    parameter int CLK_DIV = 104
) (
    input  logic CLK,
    input  logic RESET_N,
    input  logic load,
    output logic bit_done
);

    localparam int              CNT_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= RELOAD;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign bit_done = (r_cnt == '0);

endmodule

// File: rtl/uart_tx_drain.sv
// Drains an upstream FIFO one word at a time onto a UART TXD line.
// Define UART_TX_PARITY_EN to append an even parity bit after the data bits.
module uart_tx_drain
    import uart_pkg::*;
#(
    parameter int data_width = 8,
    parameter int CLK_DIV    = 104
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  FIFO_EMPTY,
    output logic                  FIFO_REN,
    input  logic [data_width-1:0] FIFO_RDAT,
    input  logic                  FIFO_RDAT_EN,
    output logic                  TXD,
    output logic                  BUSY
);

    localparam int              IDX_W    = (data_width > 1) ? $clog2(data_width) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(data_width - 1);

    tx_state_t             r_state, w_state_next;
    logic                  r_rst_done;
    logic                  r_wait_cnt, w_wait_cnt_next;
    logic [IDX_W-1:0]      r_bit_idx, w_bit_idx_next;
    logic [data_width-1:0] r_shift, w_shift_next;
    logic                  r_txd, w_txd_next;
    logic                  r_busy;
    logic                  r_fifo_ren;
    logic                  w_bit_load;
    logic                  w_bit_done;
`ifdef UART_TX_PARITY_EN
    logic                  r_parity, w_parity_next;
`endif

    uart_bit_timer #(.CLK_DIV(CLK_DIV)) u_bit_timer (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .load     (w_bit_load),
        .bit_done (w_bit_done)
    );

    // Outputs are registered from the next state so TXD, BUSY and FIFO_REN never glitch.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state    <= IDLE;
            r_rst_done <= 1'b0;
            r_wait_cnt <= 1'b0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_txd      <= UART_IDLE_LVL;
            r_busy     <= 1'b0;
            r_fifo_ren <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_next;
            r_rst_done <= 1'b1;
            r_wait_cnt <= w_wait_cnt_next;
            r_bit_idx  <= w_bit_idx_next;
            r_shift    <= w_shift_next;
            r_txd      <= w_txd_next;
            r_busy     <= (w_state_next != IDLE);
            r_fifo_ren <= (w_state_next == FETCH);
`ifdef UART_TX_PARITY_EN
            r_parity   <= w_parity_next;
`endif
        end
    end

    // NOTE: every combinational output is defaulted first so no path can infer a latch.
    always_comb begin
        w_state_next    = r_state;
        w_wait_cnt_next = r_wait_cnt;
        w_bit_idx_next  = r_bit_idx;
        w_shift_next    = r_shift;
        w_bit_load      = 1'b0;
        w_txd_next      = UART_IDLE_LVL;
`ifdef UART_TX_PARITY_EN
        w_parity_next   = r_parity;
`endif

        case (r_state)
            IDLE: begin
                // The first edge after reset release only arms r_rst_done.
                if (r_rst_done && !FIFO_EMPTY) begin
                    w_state_next = FETCH;
                end
            end
            FETCH: begin
                w_state_next    = WAIT;
                w_wait_cnt_next = 1'b0;
            end
            WAIT: begin
                if (FIFO_RDAT_EN) begin
                    w_shift_next = FIFO_RDAT;
`ifdef UART_TX_PARITY_EN
                    w_parity_next = ^FIFO_RDAT;
`endif
                    w_bit_load   = 1'b1;
                    w_state_next = START;
                end else if (r_wait_cnt) begin
                    w_state_next = IDLE;
                end else begin
                    w_wait_cnt_next = 1'b1;
                end
            end
            START: begin
                if (w_bit_done) begin
                    w_bit_idx_next = '0;
                    w_bit_load     = 1'b1;
                    w_state_next   = DATA;
                end
            end
            DATA: begin
                if (w_bit_done) begin
                    w_bit_load = 1'b1;
                    if (r_bit_idx == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
                        w_state_next = PARITY;
`else
                        w_state_next = STOP;
`endif
                    end else begin
                        w_bit_idx_next = r_bit_idx + IDX_W'(1);
                        w_shift_next   = r_shift >> 1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (w_bit_done) begin
                    w_bit_load   = 1'b1;
                    w_state_next = STOP;
                end
            end
`endif
            STOP: begin
                if (w_bit_done) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase

        case (w_state_next)
            START:   w_txd_next = UART_START_LVL;
            DATA:    w_txd_next = w_shift_next[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  w_txd_next = w_parity_next;
`endif
            STOP:    w_txd_next = UART_STOP_LVL;
            default: w_txd_next = UART_IDLE_LVL;
        endcase
    end

    assign TXD      = r_txd;
    assign BUSY     = r_busy;
    assign FIFO_REN = r_fifo_ren;

endmodule
